// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the data-memory load/store unit.
//   lsu_state_t : control states of dmem_lsu.
//   F3_*        : RV32I load/store funct3 encodings.
//   req_fault() : flags a misaligned access or an illegal funct3 for a request.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants exist only for loads, so for stores they are illegal.
  function automatic logic req_fault(input logic       we,
                                     input logic [2:0] f3,
                                     input logic [1:0] a);
    logic f;
    f = 1'b0;
    case (f3)
      F3_B:    f = 1'b0;
      F3_H:    f = a[0];
      F3_W:    f = (a != 2'b00);
      F3_BU:   f = we;
      F3_HU:   f = we | a[0];
      default: f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for dmem_lsu.
//   funct3    in  RV32I funct3 of the access
//   addr      in  byte offset within the word (addr[1:0])
//   word      in  word read from data memory
//   wdata     in  low halfword of the store data
//   load_data out sign/zero-extended load result (0 for illegal funct3)
//   merged    out word with the store byte/halfword inserted; other bytes kept
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[7:0];
    case (addr)
      2'd0: lane_b = word[7:0];
      2'd1: lane_b = word[15:8];
      2'd2: lane_b = word[23:16];
      2'd3: lane_b = word[31:24];
      default: lane_b = word[7:0];
    endcase
    lane_h = addr[1] ? word[31:16] : word[15:0];

    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
      F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
      F3_W:    load_data = word;
      F3_BU:   load_data = {24'd0, lane_b};
      F3_HU:   load_data = {16'd0, lane_h};
      default: load_data = '0;
    endcase

    merged = word;
    case (funct3)
      F3_B: begin
        case (addr)
          2'd0: merged[7:0]   = wdata[7:0];
          2'd1: merged[15:8]  = wdata[7:0];
          2'd2: merged[23:16] = wdata[7:0];
          2'd3: merged[31:24] = wdata[7:0];
          default: merged = word;
        endcase
      end
      F3_H: begin
        if (addr[1]) merged[31:16] = wdata;
        else         merged[15:0]  = wdata;
      end
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: RV32I load/store unit in front of a word-wide data memory.
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   req_*           core request handshake: we, funct3, byte addr, store data
//   rsp_*           response handshake: extended load data, error flag
//   mem_addr        word index (byte address >> 2)
//   mem_wdata       word to write
//   mem_we          single-cycle write strobe
//   mem_rdata       combinational read data for mem_addr
// Sub-word stores read the word in ACCESS and write the merged word in WRITE.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int d_width = 32,
  parameter int a_width = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [2:0]         req_funct3,
  input  logic [a_width-1:0] req_addr,
  input  logic [d_width-1:0] req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [d_width-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic [a_width-1:0] mem_addr,
  output logic [d_width-1:0] mem_wdata,
  output logic               mem_we,
  input  logic [d_width-1:0] mem_rdata
);

  lsu_state_t   state, state_nx;

  logic         we_q;
  logic [2:0]   f3_q;
  logic [1:0]   addr_lo_q;
  logic [15:0]  wdata_lo_q;
  logic [d_width-1:0] rdata_q;
  logic         err_q;
  logic [a_width-1:0] mem_addr_q;
  logic [d_width-1:0] mem_wdata_q;

  logic         fault;
  logic [d_width-1:0] load_data;
  logic [d_width-1:0] merged;

  assign fault = req_fault(req_we, req_funct3, req_addr[1:0]);

  lsu_align u_align (
    .funct3    (f3_q),
    .addr      (addr_lo_q),
    .word      (mem_rdata),
    .wdata     (wdata_lo_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // mem_we is decoded from state so the asynchronous reset drops it at once.
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_we    = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = fault ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (we_q && f3_q == F3_W) mem_we = 1'b1;
        state_nx = (we_q && f3_q != F3_W) ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        mem_we   = 1'b1;
        state_nx = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // mem_addr/mem_wdata are loaded at accept only when memory will be touched,
  // so faulting requests leave the memory port untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      f3_q        <= '0;
      addr_lo_q   <= '0;
      wdata_lo_q  <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            f3_q       <= req_funct3;
            addr_lo_q  <= req_addr[1:0];
            wdata_lo_q <= req_wdata[15:0];
            rdata_q    <= '0;
            err_q      <= fault;
            if (!fault) begin
              mem_addr_q <= {2'b00, req_addr[a_width-1:2]};
              if (req_we && req_funct3 == F3_W) mem_wdata_q <= req_wdata;
            end
          end
        end
        ST_ACCESS: begin
          if (!we_q)              rdata_q     <= load_data;
          else if (f3_q != F3_W)  mem_wdata_q <= merged;
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  dmem_lsu #(.d_width(32), .a_width(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: combinational read, write on the mem_we edge.
  logic [31:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[1] = 32'h89AB_CDEF;
    mem[3] = 32'h0123_4567;
  end
  always @(posedge clk) if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[3:0]];

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwe;
    int          we_cyc;
    logic [31:0] we_addr;
    logic [31:0] we_data;
    int          acc;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   active = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   we_cnt = 0;
  int   we_cyc_seen = 0;
  logic [31:0] we_addr_seen = '0;
  logic [31:0] we_data_seen = '0;
  int   last_wait = 0;

  task automatic check(input string nm, input int id,
                       input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s #%0d: actual %h required %h", nm, id, act, req);
    end
  endtask

  // Monitor: pops an expectation when a response appears, checks it each
  // cycle it is held, and checks memory writes at the handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      active = 1'b0;
      we_cnt = 0;
    end else begin
      if (mem_we) begin
        we_cnt++;
        we_addr_seen = mem_addr;
        we_data_seen = mem_wdata;
        we_cyc_seen  = (q.size() > 0) ? cyc - q[0].acc + 1 : -1;
      end
      if (rsp_valid) begin
        if (!active) begin
          if (q.size() == 0) begin
            check("unexpected_rsp", 0, {31'd0, rsp_valid}, 32'd0);
          end else begin
            cur = q.pop_front();
            active = 1'b1;
            check("latency", cur.id, cyc - cur.acc + 1, cur.lat);
          end
        end
        if (active) begin
          check("rdata", cur.id, rsp_rdata, cur.rdata);
          check("err", cur.id, {31'd0, rsp_err}, {31'd0, cur.err});
          check("req_ready_busy", cur.id, {31'd0, req_ready}, 32'd0);
          if (rsp_ready) begin
            check("we_count", cur.id, we_cnt, cur.nwe);
            if (cur.nwe > 0) begin
              check("we_cycle", cur.id, we_cyc_seen, cur.we_cyc);
              check("we_addr", cur.id, we_addr_seen, cur.we_addr);
              check("we_data", cur.id, we_data_seen, cur.we_data);
            end
            we_cnt = 0;
            active = 1'b0;
          end
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input exp_t e, input bit want, input int hold);
    logic rdy;
    int   n;
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    if (hold > 0) rsp_ready = 1'b0;
    last_wait = 0;
    forever begin
      @(negedge clk); rdy = req_ready;
      @(posedge clk); #1;
      if (rdy) break;
      last_wait++;
      if (last_wait > 20) begin
        $display("FAIL accept_timeout #%0d: actual no accept required accept", e.id);
        $fatal(1);
      end
    end
    req_valid = 1'b0;
    e.acc = cyc;
    if (!want) return;
    q.push_back(e);
    if (hold > 0) begin
      n = 0;
      do begin
        @(negedge clk); n++;
        if (n > 20) begin
          $display("FAIL rsp_timeout #%0d: actual no rsp_valid required rsp_valid", e.id);
          $fatal(1);
        end
      end while (!rsp_valid);
      repeat (hold) begin @(posedge clk); #1; end
      rsp_ready = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n > 30) begin
        $display("FAIL handshake_timeout #%0d: actual none required handshake", e.id);
        $fatal(1);
      end
    end while (!(rsp_valid && rsp_ready));
    @(posedge clk); #1;
  endtask

  task automatic ld(input int id, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] d, input int hold);
    exp_t e;
    e = '{id: id, rdata: d, err: 1'b0, lat: 2, nwe: 0, we_cyc: 0,
          we_addr: 32'd0, we_data: 32'd0, acc: 0};
    issue(1'b0, f3, a, 32'hFFFF_FFFF, e, 1'b1, hold);
  endtask

  task automatic st(input int id, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] wd, input logic [31:0] word_out);
    exp_t e;
    int   l;
    l = (f3 == F3_W) ? 2 : 3;
    e = '{id: id, rdata: 32'd0, err: 1'b0, lat: l, nwe: 1, we_cyc: l - 1,
          we_addr: {2'b00, a[31:2]}, we_data: word_out, acc: 0};
    issue(1'b1, f3, a, wd, e, 1'b1, 0);
  endtask

  task automatic bad(input int id, input logic we, input logic [2:0] f3,
                     input logic [31:0] a);
    exp_t e;
    e = '{id: id, rdata: 32'd0, err: 1'b1, lat: 1, nwe: 0, we_cyc: 0,
          we_addr: 32'd0, we_data: 32'd0, acc: 0};
    issue(we, f3, a, 32'hFFFF_FFFF, e, 1'b1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual still running required finished");
    $fatal(1);
  end

  initial begin
    exp_t dummy;
    dummy = '{id: 99, rdata: 32'd0, err: 1'b0, lat: 0, nwe: 0, we_cyc: 0,
              we_addr: 32'd0, we_data: 32'd0, acc: 0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 0, {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", 0, {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", 0, rsp_rdata, 32'd0);
    check("rst_rsp_err",   0, {31'd0, rsp_err}, 32'd0);
    check("rst_mem_we",    0, {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr",  0, mem_addr, 32'd0);
    check("rst_mem_wdata", 0, mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    st(1, F3_W, 32'h8, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    ld(2, F3_W, 32'h8, 32'hDEAD_BEEF, 0);
    st(3, F3_B, 32'h9, 32'hFFFF_FF12, 32'hDEAD_12EF);
    ld(4, F3_B,  32'hB, 32'hFFFF_FFDE, 0);
    ld(5, F3_BU, 32'hB, 32'h0000_00DE, 0);
    ld(6, F3_H,  32'hA, 32'hFFFF_DEAD, 0);
    ld(7, F3_HU, 32'h8, 32'h0000_12EF, 0);
    ld(8, F3_B,  32'h8, 32'hFFFF_FFEF, 0);
    ld(9, F3_H,  32'h8, 32'h0000_12EF, 0);
    st(10, F3_H, 32'hE, 32'hCAFE_8001, 32'h8001_4567);
    ld(11, F3_HU, 32'hE, 32'h0000_8001, 0);
    ld(12, F3_H,  32'hE, 32'hFFFF_8001, 0);
    st(13, F3_B, 32'hF, 32'h0000_0099, 32'h9901_4567);
    ld(14, F3_W, 32'hC, 32'h9901_4567, 0);
    st(15, F3_B, 32'h4, 32'h1234_567F, 32'h89AB_CD7F);
    ld(16, F3_BU, 32'h4, 32'h0000_007F, 0);
    ld(17, F3_B,  32'h5, 32'hFFFF_FFCD, 0);

    bad(20, 1'b0, F3_W, 32'h6);
    bad(21, 1'b1, F3_H, 32'h3);
    bad(22, 1'b0, 3'b011, 32'h8);
    bad(23, 1'b1, 3'b100, 32'h8);
    bad(24, 1'b0, F3_H, 32'h5);
    bad(25, 1'b0, 3'b110, 32'h0);
    ld(26, F3_W, 32'h8, 32'hDEAD_12EF, 0);

    // Backpressure, then an immediate follow-up request.
    ld(30, F3_W, 32'hC, 32'h9901_4567, 5);
    ld(31, F3_W, 32'h4, 32'h89AB_CD7F, 0);
    check("followup_accept_wait", 31, last_wait, 32'd0);

    // Reset during the ACCESS cycle of an SH: nothing may reach memory.
    issue(1'b1, F3_H, 32'h8, 32'h0000_5555, dummy, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_req_ready", 40, {31'd0, req_ready}, 32'd1);
    check("abort_rsp_valid", 40, {31'd0, rsp_valid}, 32'd0);
    check("abort_mem_we",    40, {31'd0, mem_we}, 32'd0);
    check("abort_mem_addr",  40, mem_addr, 32'd0);
    check("abort_mem_wdata", 40, mem_wdata, 32'd0);
    check("abort_rsp_rdata", 40, rsp_rdata, 32'd0);
    check("abort_rsp_err",   40, {31'd0, rsp_err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    ld(41, F3_W, 32'h8, 32'hDEAD_12EF, 0);

    repeat (3) @(posedge clk);
    #1;
    check("pending_rsp", 0, q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit on the core side of the data memory. It accepts one RV32I load or store per request handshake and issues word-indexed accesses to the data memory. Sub-word stores use read-modify-write, because the memory writes whole words only. Loads are sign- or zero-extended, and misaligned accesses return an error without touching memory. It sits between the execute stage and the data memory port.

## Interface
- d_width, 32, data width; fixed at 32 for RV32I.
- a_width, 32, byte-address width from the core.
- clk  in  1  clock; rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- req_addr  in  a_width  byte address.
- req_wdata  in  d_width  store data; low byte or halfword used for SB/SH.
- rsp_valid  out  1  response present; held until accepted.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  d_width  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned access or illegal funct3.
- mem_addr  out  a_width  word index (byte address >> 2, zero-filled at top).
- mem_wdata  out  d_width  word to write.
- mem_we  out  1  write strobe; single-cycle pulse.
- mem_rdata  in  d_width  combinational read data for mem_addr.

## Operation
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE
  - req_ready=1.
  - On req_valid, latch we, funct3, addr and wdata.
  - If misaligned or funct3 is illegal, go to RESP with err=1.
  - Otherwise go to ACCESS.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
- Illegal funct3: loads 011, 110, 111; stores anything other than 000/001/010.
- ACCESS: mem_addr = latched addr >> 2.
  - Load: extract the lane selected by addr[1:0], extend it and register it into rsp_rdata. Go to RESP.
  - SW: mem_we=1 with mem_wdata = wdata. Go to RESP.
  - SB/SH: merge the wdata low byte or halfword into mem_rdata at lane addr[1:0], register the merged word, and go to WRITE.
- WRITE: mem_addr unchanged; mem_we=1 with mem_wdata = merged word. Go to RESP.
- RESP: rsp_valid=1, with rsp_rdata and rsp_err stable. On rsp_ready, go to IDLE.
- Lane extraction: byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
- Merge: untouched bytes of the word are preserved exactly.
- mem_we is 0 in every state except ACCESS (SW) and WRITE.
- mem_addr and mem_wdata hold their last values outside ACCESS/WRITE.

## Timing
- Reset (asynchronous): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_addr=0, mem_wdata=0, all latches=0.
- Latency from the accept edge to rsp_valid:
  - error: 1 cycle.
  - load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
- Throughput: one request in flight. req_ready=0 from the accept edge until the rsp_ready handshake completes.
- IDLE is re-entered on the rsp_valid&&rsp_ready edge, so the next request is accepted one cycle later at the earliest.
- A store's write commits on the mem_we edge. The response for that store follows on the next cycle.
- rsp_ready held low: the unit stays in RESP indefinitely with outputs stable and never reissues a memory access.
- Reset mid-operation (ACCESS/WRITE): the state machine aborts immediately and mem_we drops asynchronously. A partial SB/SH merge that has not yet been written is discarded.
- req_valid is ignored outside IDLE.

## Structure
- Shared package lsu_pkg:
  - state enum (IDLE, ACCESS, WRITE, RESP).
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
- One combinational sub-module, lsu_align:
  - inputs: funct3, addr[1:0], word, wdata.
  - outputs: extended load data and merged store word.
  - Keeps lane logic out of the state machine.

## Test plan
- SW addr 0x8, data 0xDEADBEEF:
  - mem_we pulses once with mem_addr=2.
  - rsp_valid 2 cycles after accept, rsp_err=0.
  - LW 0x8 then returns 0xDEADBEEF.
- Word 2 = 0xDEADBEEF; SB addr 0x9, data 0x12:
  - read then write, with mem_we in the WRITE cycle only.
  - word becomes 0xDEAD12EF; rsp_valid 3 cycles after accept.
- Word 2 = 0xDEAD12EF:
  - LB 0xB → 0xFFFFFFDE.
  - LBU 0xB → 0x000000DE.
  - LH 0xA → 0xFFFFDEAD.
  - LHU 0x8 → 0x000012EF.
- Misaligned LW 0x6, misaligned SH 0x3, and illegal load funct3 011:
  - each gives rsp_err=1 and rsp_rdata=0 one cycle after accept.
  - mem_we never asserts.
- Backpressure: hold rsp_ready=0 for 5 cycles after an LW.
  - rsp_valid and rsp_rdata stay stable; req_ready stays 0; no extra memory access.
  - After rsp_ready, a new request is accepted the following cycle.
- Assert rst_n low during the ACCESS cycle of an SH:
  - outputs return to reset values immediately and memory is unchanged.
  - After release, an LW to the same word returns the old value.
